// File: rtl/sched_pkg.sv
// sched_pkg: shared FSM state type and counter width for the egress scheduler mux
package sched_pkg;

    typedef enum logic {IDLE, FWD} state_t;

    localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/sched_egress_reg_slice.sv
// sched_egress_reg_slice: one-deep registered AXI-Stream output stage with in-place replace on emit
module sched_egress_reg_slice #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last
);

    // load on accept, otherwise hold until the sink takes the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sched_egress_mux.sv
// sched_egress_mux: scheduler-selected N:1 AXI-Stream egress mux, locked per packet; SCHED_EGRESS_PKT_CNT_EN adds tx_pkt_cnt
module sched_egress_mux
    import sched_pkg::*;
#(
    parameter int NUM_FIFO   = 9,
    parameter int SEL_WIDTH  = $clog2(NUM_FIFO),
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_WIDTH-1:0]           sel_in,
    input  logic                           en_in,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_FIFO*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_FIFO-1:0]            s_axis_tvalid,
    input  logic [NUM_FIFO-1:0]            s_axis_tlast,
    output logic [NUM_FIFO-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [NUM_FIFO-1:0]            pe_tlast,
    output logic                           busy
`ifdef SCHED_EGRESS_PKT_CNT_EN
    ,
    output logic [NUM_FIFO*CNT_WIDTH-1:0]  tx_pkt_cnt
`endif
);

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] cur_sel, cur_sel_nxt;
    logic                 rdy, accept;

    assign rdy  = !m_axis_tvalid || m_axis_tready;
    assign busy = (state == FWD);

    // grant a valid in-range FIFO from IDLE; while locked, only cur_sel may be accepted
    always_comb begin
        state_nxt     = state;
        cur_sel_nxt   = cur_sel;
        s_axis_tready = '0;
        accept        = 1'b0;
        if (state == IDLE) begin
            if (en_in && 32'(sel_in) < NUM_FIFO && s_axis_tvalid[sel_in]) begin
                state_nxt   = FWD;
                cur_sel_nxt = sel_in;
            end
        end else begin
            s_axis_tready[cur_sel] = rdy;
            accept                 = rdy && s_axis_tvalid[cur_sel];
            if (accept && s_axis_tlast[cur_sel])
                state_nxt = IDLE;
        end
    end

    // state, lock register and one-cycle end-of-packet pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_sel  <= '0;
            pe_tlast <= '0;
        end else begin
            state    <= state_nxt;
            cur_sel  <= cur_sel_nxt;
            pe_tlast <= (accept && s_axis_tlast[cur_sel]) ? NUM_FIFO'(1) << cur_sel : '0;
        end
    end

    sched_egress_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_reg_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (s_axis_tdata[32'(cur_sel)*DATA_WIDTH +: DATA_WIDTH]),
        .in_keep   (s_axis_tkeep[32'(cur_sel)*KEEP_WIDTH +: KEEP_WIDTH]),
        .in_last   (s_axis_tlast[cur_sel]),
        .out_ready (m_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast)
    );

`ifdef SCHED_EGRESS_PKT_CNT_EN
    // per-FIFO completed-packet counters, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_pkt_cnt <= '0;
        else
            for (int i = 0; i < NUM_FIFO; i++)
                if (pe_tlast[i])
                    tx_pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= tx_pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
    end
`endif

endmodule
